// File: rtl/ripple_adder_reg.sv
// ripple_adder_reg: N-bit ripple-carry adder with a registered, valid-qualified
// output stage. The carry chain is built from explicit full-adder cells rather
// than a behavioural '+', so the cell structure survives into the netlist.
// Combinational sum/carry are also brought out for direct inspection.

// 1-bit full adder cell
module adder_1 (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);
endmodule

// N-bit ripple chain of adder_1 cells. c_msb is the carry into the top bit,
// needed for signed overflow detection.
module adder_n #(
  parameter int N = 3
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         c_msb
);
  logic [N:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < N; i++) begin : g_cell
    adder_1 u_fa (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (carry[i]),
      .sum   (sum[i]),
      .c_out (carry[i+1])
    );
  end

  assign c_out = carry[N];
  // For N=1 this is carry[0], i.e. c_in itself.
  assign c_msb = carry[N-1];
endmodule

// Top: combinational adder plus one output register stage
module ripple_adder_reg #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum_comb,
  output logic         c_out_comb,
  output logic         out_valid,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         overflow
);
  logic c_msb;
  logic ovf_comb;

  adder_n #(.N(N)) u_add (
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .sum   (sum_comb),
    .c_out (c_out_comb),
    .c_msb (c_msb)
  );

  // Signed overflow: carry into the MSB disagrees with carry out of it
  assign ovf_comb = c_out_comb ^ c_msb;

  // Result register: reset wins, capture on valid, otherwise hold data and drop valid
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      sum       <= sum_comb;
      c_out     <= c_out_comb;
      overflow  <= ovf_comb;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ripple_adder_reg.sv
// Scoreboard bench for ripple_adder_reg. Stimulus pushes expected registered
// results into a queue; a negedge monitor pops them whenever out_valid is high.
// Expected values come from plain integer arithmetic on the operands.
module tb_ripple_adder_reg;
  localparam int N = 3;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         c_out;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [N-1:0] a, b;
  logic         c_in;
  logic [N-1:0] sum_comb, sum;
  logic         c_out_comb, out_valid, c_out, overflow;

  // 1-bit instance for the exhaustive cell check
  logic a1, b1, cin1, iv1;
  logic s1c, c1c, ov1v, s1, c1, ovf1;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb_q[$];
  exp_t held;   // registered state the model expects when nothing is captured

  ripple_adder_reg #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c_in(c_in),
    .sum_comb(sum_comb), .c_out_comb(c_out_comb), .out_valid(out_valid),
    .sum(sum), .c_out(c_out), .overflow(overflow)
  );

  ripple_adder_reg #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .c_in(cin1),
    .sum_comb(s1c), .c_out_comb(c1c), .out_valid(ov1v),
    .sum(s1), .c_out(c1), .overflow(ovf1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: unsigned sum/carry and signed-range overflow from integers
  function automatic exp_t model(input int ai, input int bi, input int ci);
    exp_t e;
    int u, sa, sb, s;
    u  = ai + bi + ci;
    sa = (ai >= 4) ? ai - 8 : ai;
    sb = (bi >= 4) ? bi - 8 : bi;
    s  = sa + sb + ci;
    e.sum   = u[N-1:0];
    e.c_out = (u > 7);
    e.ovf   = (s > 3) || (s < -4);
    return e;
  endfunction

  // Monitor: every presented result must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out: out_valid with empty scoreboard at %0t", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("reg_sum", 32'(sum), 32'(e.sum));
        chk("reg_c_out", 32'(c_out), 32'(e.c_out));
        chk("reg_ovf", 32'(overflow), 32'(e.ovf));
      end
    end
  end

  // One cycle of stimulus; checks comb outputs, then either queues a result
  // or checks that the register held (or cleared, under reset).
  task automatic issue(input logic r, input logic v, input int ai, input int bi, input int ci);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v;
    a = ai[N-1:0]; b = bi[N-1:0]; c_in = ci[0];
    e = model(ai, bi, ci);
    #1;
    chk("comb_sum", 32'(sum_comb), 32'(e.sum));
    chk("comb_c_out", 32'(c_out_comb), 32'(e.c_out));
    if (r) held = '0;
    else if (v) held = e;
    if (v && !r) begin
      sb_q.push_back(e);
    end else begin
      @(posedge clk); #1;
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_sum", 32'(sum), 32'(held.sum));
      chk("idle_c_out", 32'(c_out), 32'(held.c_out));
      chk("idle_ovf", 32'(overflow), 32'(held.ovf));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; iv1 = 1'b0;
    held = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // 1-bit cell, all 8 input combinations
    for (int k = 0; k < 8; k++) begin
      int cnt;
      {cin1, a1, b1} = k[2:0];
      cnt = int'(cin1) + int'(a1) + int'(b1);
      #1;
      chk("n1_sum", 32'(s1c), 32'(cnt % 2));
      chk("n1_c_out", 32'(c1c), 32'(cnt >= 2));
    end

    // 3-bit exhaustive, random valid so the register path is exercised too
    for (int ci = 0; ci < 2; ci++)
      for (int ai = 0; ai < 8; ai++)
        for (int bi = 0; bi < 8; bi++)
          issue(1'b0, 1'($urandom_range(0, 1)), ai, bi, ci);

    // Signed overflow corner cases
    issue(0, 1, 3, 1, 0);
    issue(0, 1, 4, 4, 0);
    issue(0, 1, 7, 1, 0);

    // Latency and hold
    issue(0, 1, 5, 2, 1);
    issue(0, 0, 3, 6, 0);
    issue(0, 0, 1, 2, 1);

    // Reset beats valid, then resume
    issue(1, 1, 3, 3, 0);
    issue(0, 1, 1, 1, 0);
    issue(0, 0, 0, 0, 0);

    // Streaming: eight back-to-back pairs summing to 7
    for (int i = 0; i < 8; i++) issue(0, 1, i, 7 - i, 0);
    issue(0, 0, 0, 0, 0);

    // Random mix including occasional reset
    for (int k = 0; k < 300; k++)
      issue(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 1)));

    issue(0, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
